// File: rtl/fw_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fw_axi_pkg
// Brief    : Shared states, response/burst codes and address field positions
//            for the AXI write channel router.
// Revision : 1.0
// ============================================================================
package fw_axi_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int CH_LSB   = 4;
  localparam int CH_MSB   = 7;
  localparam int MARK_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/fw_index_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fw_index_ctr
// Brief    : Wrap-around record index counter with synchronous clear.
// Revision : 1.0
// ============================================================================
module fw_index_ctr #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_chan_router.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_chan_router
// Brief    : AXI4 write slave routing each burst's beats to one of NUM_CH FIFOs.
// Revision : 1.0
// ============================================================================
module axi_wr_chan_router
  import fw_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [NUM_CH-1:0]   ch_full,
  output logic [NUM_CH-1:0]   ch_push,
  output logic [NUM_CH-1:0]   ch_clr,
  output logic [DATA_W-1:0]   push_data,
  output logic [DATA_W/8-1:0] push_strb,
  output logic [IDX_W-1:0]    push_index,
  output logic                push_last
);

  state_t            r_state;
  logic [ID_W-1:0]   r_id;
  logic [3:0]        r_ch;
  logic              r_mark;
  logic              r_err;
  logic [7:0]        r_beats;

  logic [IDX_W-1:0]  w_index [NUM_CH];
  logic [IDX_W-1:0]  w_cur_index;
  logic              w_full;
  logic              w_last_beat;
  logic              w_w_hs;
  logic              w_push;
  logic              w_dec_err;
  logic [NUM_CH-1:0] w_push_vec;
  logic [NUM_CH-1:0] w_inc;
  logic              w_unused;

  assign w_unused = ^awaddr[ADDR_W-1:CH_MSB+1];

  assign w_dec_err = ({1'b0, awaddr[CH_MSB:CH_LSB]} >= 5'(NUM_CH))
                   || (awaddr[CH_LSB-1:MARK_BIT+1] != '0)
                   || (awburst == BURST_WRAP);

  // Guarded selection keeps out-of-range channel codes from indexing past NUM_CH.
  always_comb begin
    w_full      = 1'b0;
    w_cur_index = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == 4'(i)) begin
        w_full      = ch_full[i];
        w_cur_index = w_index[i];
      end
    end
  end

  assign awready     = ~reset && (r_state == ST_IDLE);
  assign wready      = ~reset && (((r_state == ST_DATA) && ~w_full) || (r_state == ST_DRAIN));
  assign bvalid      = ~reset && (r_state == ST_RESP);
  assign ch_clr      = {NUM_CH{~reset && (r_state == ST_INIT)}};
  assign w_w_hs      = wvalid && wready;
  assign w_last_beat = (r_beats == 8'd0);
  assign w_push      = w_w_hs && (r_state == ST_DATA);

  assign bid        = bvalid ? r_id : '0;
  assign bresp      = (bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign ch_push    = w_push_vec;
  assign push_data  = w_push ? wdata : '0;
  assign push_strb  = w_push ? wstrb : '0;
  assign push_index = w_push ? w_cur_index : '0;
  assign push_last  = w_push && r_mark && w_last_beat;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_push_vec[gi] = w_push && (r_ch == 4'(gi));
    assign w_inc[gi]      = w_push_vec[gi] && r_mark && w_last_beat;

    fw_index_ctr #(.IDX_W(IDX_W)) u_index_ctr (
      .clk   (clk),
      .clr   (reset),
      .inc   (w_inc[gi]),
      .count (w_index[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_id    <= '0;
      r_ch    <= '0;
      r_mark  <= 1'b0;
      r_err   <= 1'b0;
      r_beats <= '0;
    end else begin
      case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (awvalid) begin
            r_id    <= awid;
            r_ch    <= awaddr[CH_MSB:CH_LSB];
            r_mark  <= awaddr[MARK_BIT];
            r_beats <= awlen;
            r_err   <= w_dec_err;
            r_state <= w_dec_err ? ST_DRAIN : ST_DATA;
          end
        end
        // The beat count, not wlast, decides where the burst ends.
        ST_DATA, ST_DRAIN: begin
          if (w_w_hs) begin
            if (wlast != w_last_beat) r_err <= 1'b1;
            r_beats <= r_beats - 8'd1;
            if (w_last_beat) r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bready) begin
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire
